// File: rtl/prom_arbiter.sv
// prom_arbiter: two-requester (CPU, AUX) read sequencer for the P1 program ROM.
// Generates registered ROM_nCE/ROM_nOE timing from CLK_24M, latches the ROM
// word into RDATA and returns it with a one-cycle ACK to the granted requester.
// CPU has priority; AUX is forced through after STARVE_LIMIT consecutive CPU
// grants made while AUX was waiting.
// Optional feature: define PROM_BYTESWAP_EN to byte-swap the latched ROM word
// (undoes a byte-swapped image layout). Default build latches ROM_DATA as-is.
module prom_arbiter #(
    parameter int unsigned ACCESS_CYCLES   = 3,  // 1..15, nOE-low cycles before sampling
    parameter int unsigned RECOVERY_CYCLES = 1,  // 0..7, nCE-high cycles after each access
    parameter int unsigned STARVE_LIMIT    = 4   // 1..15, CPU grants tolerated while AUX waits
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        CPU_REQ,
    input  logic [19:0] CPU_ADDR,
    output logic        CPU_ACK,
    input  logic        AUX_REQ,
    input  logic [19:0] AUX_ADDR,
    output logic        AUX_ACK,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic [19:0] ROM_ADDR,
    output logic        ROM_nCE,
    output logic        ROM_nOE,
    input  logic [15:0] ROM_DATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_RECOVER
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } owner_t;

    // Counter reload values: counters run down to zero, so load (cycles - 1).
    localparam logic [3:0] ACC_LOAD   = 4'(ACCESS_CYCLES - 1);
    localparam logic [2:0] REC_LOAD   = (RECOVERY_CYCLES == 0) ? 3'd0 : 3'(RECOVERY_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_next_state;
    owner_t      r_owner;
    logic [3:0]  r_acc_cnt;
    logic [2:0]  r_rec_cnt;
    logic [3:0]  r_starve_cnt;
    logic        w_grant;
    logic        w_grant_aux;
    logic [15:0] w_rom_word;

    logic        r_cpu_ack;
    logic        r_aux_ack;
    logic [15:0] r_rdata;
    logic        r_busy;
    logic [19:0] r_rom_addr;
    logic        r_rom_nce;
    logic        r_rom_noe;

    // Word presented to RDATA: optionally byte-swapped image layout.
`ifdef PROM_BYTESWAP_EN
    assign w_rom_word = {ROM_DATA[7:0], ROM_DATA[15:8]};
`else
    assign w_rom_word = ROM_DATA;
`endif

    // Next-state and arbitration decision.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_aux  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CPU_REQ || AUX_REQ) begin
                    w_grant      = 1'b1;
                    // AUX wins when alone, or when the CPU has starved it long enough.
                    w_grant_aux  = AUX_REQ && (!CPU_REQ || (r_starve_cnt == STARVE_MAX));
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_acc_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = (RECOVERY_CYCLES == 0) ? S_IDLE : S_RECOVER;
            end
            S_RECOVER: begin
                if (r_rec_cnt == 3'd0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant bookkeeping: address capture, owner and the starvation counter.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_rom_addr   <= 20'd0;
            r_owner      <= OWN_CPU;
            r_starve_cnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_aux) begin
                r_rom_addr   <= AUX_ADDR;
                r_owner      <= OWN_AUX;
                r_starve_cnt <= 4'd0;
            end else if (w_grant) begin
                r_rom_addr <= CPU_ADDR;
                r_owner    <= OWN_CPU;
                if (!AUX_REQ) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                // Idle with nobody asking: AUX_REQ is low, so the count clears.
                r_starve_cnt <= 4'd0;
            end
        end
    end

    // Access and recovery down-counters, loaded in the state before each phase.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_acc_cnt <= 4'd0;
            r_rec_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_SETUP:   r_acc_cnt <= ACC_LOAD;
                S_ACCESS:  if (r_acc_cnt != 4'd0) r_acc_cnt <= r_acc_cnt - 4'd1;
                S_DONE:    r_rec_cnt <= REC_LOAD;
                S_RECOVER: if (r_rec_cnt != 3'd0) r_rec_cnt <= r_rec_cnt - 3'd1;
                default:   ;
            endcase
        end
    end

    // Read data latch: captured on the edge that ends the last ACCESS cycle.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_rdata <= 16'd0;
        end else if ((r_state == S_ACCESS) && (r_acc_cnt == 4'd0)) begin
            r_rdata <= w_rom_word;
        end
    end

    // Registered pin and handshake outputs, decoded from the state being entered
    // so they change on the same edge as the state itself.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            r_rom_nce <= 1'b1;
            r_rom_noe <= 1'b1;
            r_cpu_ack <= 1'b0;
            r_aux_ack <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rom_nce <= !((w_next_state == S_SETUP) || (w_next_state == S_ACCESS));
            r_rom_noe <= (w_next_state != S_ACCESS);
            r_cpu_ack <= (w_next_state == S_DONE) && (r_owner == OWN_CPU);
            r_aux_ack <= (w_next_state == S_DONE) && (r_owner == OWN_AUX);
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    assign ROM_ADDR = r_rom_addr;
    assign ROM_nCE  = r_rom_nce;
    assign ROM_nOE  = r_rom_noe;
    assign CPU_ACK  = r_cpu_ack;
    assign AUX_ACK  = r_aux_ack;
    assign RDATA    = r_rdata;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_prom_arbiter.sv
// Directed bench for prom_arbiter: reset, single read, starvation order,
// mid-access reset and a zero-recovery instance. Expected values are computed
// from a simple ROM content rule (word = addr[15:0] + 16'h1134).
module tb_prom_arbiter;

    localparam int N = 3;   // ACCESS_CYCLES
    localparam int R = 1;   // RECOVERY_CYCLES of the main instance

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    // Main instance (defaults)
    logic        cpu_req, aux_req, cpu_ack, aux_ack, busy, rom_nce, rom_noe;
    logic [19:0] cpu_addr, aux_addr, rom_addr;
    logic [15:0] rdata, rom_data;

    // Zero-recovery instance
    logic        r0_req, r0_aux_req, r0_ack, r0_aux_ack, r0_busy, r0_nce, r0_noe;
    logic [19:0] r0_addr, r0_aux_addr, r0_rom_addr;
    logic [15:0] r0_rdata, r0_rom_data;

    int n_tests = 0;
    int n_fail  = 0;

    prom_arbiter dut (
        .CLK_24M(clk), .nRESET(rst_n),
        .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_ACK(cpu_ack),
        .AUX_REQ(aux_req), .AUX_ADDR(aux_addr), .AUX_ACK(aux_ack),
        .RDATA(rdata), .BUSY(busy), .ROM_ADDR(rom_addr),
        .ROM_nCE(rom_nce), .ROM_nOE(rom_noe), .ROM_DATA(rom_data)
    );

    prom_arbiter #(.ACCESS_CYCLES(3), .RECOVERY_CYCLES(0), .STARVE_LIMIT(4)) dut_r0 (
        .CLK_24M(clk), .nRESET(rst_n),
        .CPU_REQ(r0_req), .CPU_ADDR(r0_addr), .CPU_ACK(r0_ack),
        .AUX_REQ(r0_aux_req), .AUX_ADDR(r0_aux_addr), .AUX_ACK(r0_aux_ack),
        .RDATA(r0_rdata), .BUSY(r0_busy), .ROM_ADDR(r0_rom_addr),
        .ROM_nCE(r0_nce), .ROM_nOE(r0_noe), .ROM_DATA(r0_rom_data)
    );

    function automatic logic [15:0] rom_word(input logic [19:0] a);
        return a[15:0] + 16'h1134;
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [19:0] a);
        logic [15:0] w;
        w = rom_word(a);
`ifdef PROM_BYTESWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    // ROM models: drive the word only while output-enabled, all-ones otherwise.
    always_comb rom_data    = (!rom_noe && !rom_nce) ? rom_word(rom_addr)    : 16'hFFFF;
    always_comb r0_rom_data = (!r0_noe  && !r0_nce)  ? rom_word(r0_rom_addr) : 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 50) begin
            tick();
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int noe_low, ack_cnt, ack_edge, aux_seen, g, cyc, last, min_hi, hi_run, acks;
        logic seen_access, prev_nce;

        rst_n       = 1'b0;
        cpu_req     = 1'b1;
        cpu_addr    = 20'h00100;
        aux_req     = 1'b0;
        aux_addr    = 20'h00000;
        r0_req      = 1'b0;
        r0_addr     = 20'h00400;
        r0_aux_req  = 1'b0;
        r0_aux_addr = 20'h00000;

        // ---------------- Reset held with CPU_REQ high ----------------
        repeat (3) tick();
        check("rst_nce",   32'(rom_nce), 32'd1);
        check("rst_noe",   32'(rom_noe), 32'd1);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_ack",   32'({cpu_ack, aux_ack}), 32'd0);
        check("rst_rdata", 32'(rdata),   32'd0);
        check("rst_addr",  32'(rom_addr), 32'd0);
        check("rst_r0_busy", 32'(r0_busy), 32'd0);

        // ---------------- Release: grant on first edge, single CPU read ----------------
        rst_n = 1'b1;
        tick();  // edge k
        check("grant_busy", 32'(busy),     32'd1);
        check("grant_nce",  32'(rom_nce),  32'd0);
        check("grant_noe",  32'(rom_noe),  32'd1);
        check("grant_addr", 32'(rom_addr), 32'h00100);
        cpu_req = 1'b0;  // dropped before ACK: access must still complete
        noe_low = 0; ack_cnt = 0; ack_edge = -1; aux_seen = 0;
        for (int i = 1; i <= N + R + 2; i++) begin
            tick();
            if (!rom_noe) noe_low++;
            if (cpu_ack) begin
                ack_cnt++;
                ack_edge = i;
            end
            if (aux_ack) aux_seen++;
        end
        check("read_noe_cycles", 32'(noe_low),  32'd3);
        check("read_ack_count",  32'(ack_cnt),  32'd1);
        check("read_ack_edge",   32'(ack_edge), 32'(N + 1));
        check("read_no_aux_ack", 32'(aux_seen), 32'd0);
        check("read_rdata",      32'(rdata),    32'(exp_rdata(20'h00100)));
        check("read_idle",       32'(busy),     32'd0);
        check("read_nce_high",   32'(rom_nce),  32'd1);
        repeat (3) tick();
        check("rdata_hold",      32'(rdata),    32'(exp_rdata(20'h00100)));

        // ---------------- Starvation: both held high ----------------
        cpu_addr = 20'h00200;
        aux_addr = 20'h0ABCD;
        cpu_req  = 1'b1;
        aux_req  = 1'b1;
        g = 0; cyc = 0; last = -1;
        while (g < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (cpu_ack || aux_ack) begin
                check("ack_exclusive", 32'(cpu_ack & aux_ack), 32'd0);
                check($sformatf("grant_%0d_is_aux", g), 32'(aux_ack), 32'((g % 5) == 4));
                check($sformatf("grant_%0d_rdata", g), 32'(rdata),
                      32'(exp_rdata(aux_ack ? aux_addr : cpu_addr)));
                if (last >= 0) check($sformatf("grant_%0d_period", g), 32'(cyc - last), 32'(N + R + 3));
                last = cyc;
                g++;
                if (g == 10) begin
                    cpu_req = 1'b0;
                    aux_req = 1'b0;
                end
            end
        end
        check("starve_grants", 32'(g), 32'd10);
        wait_idle("starve_idle");

        // ---------------- Mid-access reset ----------------
        cpu_addr = 20'h00300;
        cpu_req  = 1'b1;
        tick();  // grant edge
        tick();  // into ACCESS
        tick();
        #5 rst_n = 1'b0;
        #1;
        check("midrst_nce",   32'(rom_nce),  32'd1);
        check("midrst_noe",   32'(rom_noe),  32'd1);
        check("midrst_busy",  32'(busy),     32'd0);
        check("midrst_addr",  32'(rom_addr), 32'd0);
        check("midrst_rdata", 32'(rdata),    32'd0);
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack || aux_ack) ack_cnt++;
        end
        check("midrst_no_ack", 32'(ack_cnt), 32'd0);
        rst_n = 1'b1;
        tick();  // grant edge for the still-pending request
        check("midrst_regrant", 32'(rom_addr), 32'h00300);
        cpu_req = 1'b0;
        ack_edge = -1;
        for (int i = 1; i <= 10 && ack_edge < 0; i++) begin
            tick();
            if (cpu_ack) ack_edge = i;
        end
        check("midrst_ack_edge", 32'(ack_edge), 32'(N + 1));
        check("midrst_rdata_after", 32'(rdata), 32'(exp_rdata(20'h00300)));
        wait_idle("midrst_idle");

        // ---------------- Zero recovery, continuous CPU_REQ ----------------
        r0_req = 1'b1;
        acks = 0; cyc = 0; last = -1; min_hi = 99; hi_run = 0;
        seen_access = 1'b0; prev_nce = r0_nce; aux_seen = 0;
        while (acks < 5 && cyc < 60) begin
            tick();
            cyc++;
            if (r0_aux_ack) aux_seen++;
            if (r0_nce) hi_run++;
            if (!r0_nce && prev_nce) begin
                if (seen_access && hi_run < min_hi) min_hi = hi_run;
                seen_access = 1'b1;
            end
            if (!r0_nce) hi_run = 0;
            prev_nce = r0_nce;
            if (r0_ack) begin
                check($sformatf("r0_ack_%0d_rdata", acks), 32'(r0_rdata), 32'(exp_rdata(20'h00400)));
                if (last >= 0) check($sformatf("r0_ack_%0d_period", acks), 32'(cyc - last), 32'(N + 3));
                last = cyc;
                acks++;
            end
        end
        r0_req = 1'b0;
        check("r0_ack_count", 32'(acks), 32'd5);
        check("r0_nce_gap_min1", 32'(min_hi >= 1 && min_hi != 99), 32'd1);
        check("r0_no_aux_ack", 32'(aux_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
